// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with valid/ready handshake, stall/flush control and bubble suppression.
// Defining PIPE_STAGE_SKID_EN builds a two-entry skid buffer; otherwise it holds one entry.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        count
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic              head_valid;
    logic              accept;
    logic              emit;
    logic              hold;

    assign hold   = stall | flush;
    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    assign out_valid = head_valid & ~hold;
    assign out_ctrl  = out_valid ? head_ctrl_q : CTRL_W'(0);
    assign out_data  = head_data_q;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;

    // Registered ready keeps out_ready off the in_ready path.
    assign in_ready   = in_ready_q & ~hold;
    assign head_valid = (state_q != S_EMPTY);
    assign count      = 2'(state_q);

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d     = S_ONE;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                S_ONE: begin
                    if (accept && emit) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d     = S_TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (emit) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only an emit can happen
                    if (emit) begin
                        state_d     = S_ONE;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end
`else
    logic run_q;

    // run_q holds in_ready low until the first edge after reset release.
    assign in_ready   = run_q & ((state_q == S_EMPTY) | out_ready) & ~hold;
    assign head_valid = (state_q == S_FULL);
    assign count      = {1'b0, head_valid};

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d     = S_FULL;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                S_FULL: begin
                    if (accept) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (emit) begin
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf; accepted entries are queued and checked as they emerge.
`timescale 1ns/1ps
module tb_pipe_stage_buf;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int peak  = 0;
    logic [39:0] exp_q[$];

`ifdef PIPE_STAGE_SKID_EN
    localparam int PEAK_EXP = 2;
`else
    localparam int PEAK_EXP = 1;
`endif

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall(stall), .flush(flush), .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present one entry and hold it until the stage takes it.
    task automatic send(input logic [31:0] d, input logic [7:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (in_ready) begin
                cyc();
                return;
            end
            cyc();
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: entry 0x%0h never accepted", d);
    endtask

    task automatic wait_empty();
        int t;
        out_ready = 1'b1;
        for (t = 0; t < 30; t++) begin
            if (count == 2'd0) break;
            cyc();
        end
        check("drain_count", 32'(count), 32'd0);
    endtask

    // Monitor: pop and compare on emit, push on accept, drop everything on flush.
    always @(negedge clock) begin
        if (!reset) begin
            if (32'(count) > peak) peak = 32'(count);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_emit", {24'd0, out_ctrl}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", out_data, exp_q[0][31:0]);
                    check("out_ctrl", {24'd0, out_ctrl}, {24'd0, exp_q[0][39:32]});
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
            if (!out_valid) check("bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
            if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
            if (flush) exp_q.delete();
        end
    end

    initial begin
        int idx;
        logic r0;

        // Reset state
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        cyc();
        reset = 1'b0;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        cyc();
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Single entry, one-cycle latency
        out_ready = 1'b1;
        send(32'h0040_0004, 8'h15);
        in_valid = 1'b0;
        #1;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_data", out_data, 32'h0040_0004);
        check("lat_out_ctrl", {24'd0, out_ctrl}, 32'h15);
        check("lat_count", 32'(count), 32'd1);
        cyc();
        check("post_emit_count", 32'(count), 32'd0);
        check("post_emit_valid", 32'(out_valid), 32'd0);
        check("hold_out_data", out_data, 32'h0040_0004);

        // Back-pressure: four entries, downstream blocked for three cycles
        peak = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(32'(i), 8'(8'h10 + i));
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b0;
                repeat (3) cyc();
                out_ready = 1'b1;
            end
        join
        wait_empty();
        check("bp_peak", 32'(peak), 32'(PEAK_EXP));
        check("bp_pops", 32'(n_pop), 32'd5);

        // Stall holds the entry and blocks input
        out_ready = 1'b0;
        send(32'hA5A5_0001, 8'h3C);
        stall = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_ctrl  = 8'hFF;
        #1;
        check("stall_out_valid", 32'(out_valid), 32'd0);
        check("stall_out_ctrl", {24'd0, out_ctrl}, 32'd0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_count", 32'(count), 32'd1);
        cyc();
        cyc();
        check("stall_out_data", out_data, 32'hA5A5_0001);
        stall = 1'b0;
        in_valid = 1'b0;
        #1;
        check("unstall_valid", 32'(out_valid), 32'd1);
        check("unstall_data", out_data, 32'hA5A5_0001);
        check("unstall_ctrl", {24'd0, out_ctrl}, 32'h3C);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("unstall_drained", 32'(count), 32'd0);

        // Flush with the stage full and a coincident input
        send(32'h0000_0011, 8'h01);
`ifdef PIPE_STAGE_SKID_EN
        send(32'h0000_0022, 8'h02);
`endif
        check("pre_flush_count", 32'(count), 32'(PEAK_EXP));
        flush = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0BAD;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_valid", 32'(out_valid), 32'd0);
        cyc();
        cyc();
        check("flush_no_emit", 32'(count), 32'd0);

        // Throughput with out_ready toggling every cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            out_ready = 1'(k & 1);
            in_data = 32'h100 + 32'(idx);
            in_ctrl = 8'(idx);
            #1;
            r0 = in_ready;
`ifdef PIPE_STAGE_SKID_EN
            out_ready = ~out_ready;
            #1;
            check("ir_indep", 32'(in_ready), 32'(r0));
            out_ready = ~out_ready;
`endif
            if (r0) idx++;
            cyc();
        end
        in_valid = 1'b0;
        check("thru_min", 32'(idx >= 8), 32'd1);
        wait_empty();
        check("thru_pops", 32'(n_pop), 32'(6 + idx));

        // Asynchronous reset between edges
        out_ready = 1'b0;
        send(32'h0000_0077, 8'h07);
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        exp_q.delete();
        #1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("arst_rel_in_ready", 32'(in_ready), 32'd0);
        cyc();
        check("arst_first_edge_ready", 32'(in_ready), 32'd1);

        cyc();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
